// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for the multicycle RV32I core
// Sequences ALU, unified memory and register file; counts retired instructions.
module multicycle_controller #(
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              op,
  input  logic [2:0]              funct3,
  input  logic                    funct7b5,
  input  logic                    zero,
  output logic                    pc_write,
  output logic                    adr_src,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic [1:0]              result_src,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [2:0]              alu_control,
  output logic [1:0]              imm_src,
  output logic                    reg_write,
  output logic                    illegal,
  output logic [3:0]              state,
  output logic [RETIRE_CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_DEC = 2'd2
  } alu_mode_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [RETIRE_CNT_W-1:0] RETIRE_ONE = {{(RETIRE_CNT_W-1){1'b0}}, 1'b1};

  state_t    cur_state;
  state_t    nxt_state;
  alu_mode_t alu_mode;
  logic      pc_update;
  logic      branch;
  logic      adr_src_raw;
  logic      mem_write_raw;
  logic      ir_write_raw;
  logic      reg_write_raw;
  logic      retire;

  assign state = cur_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH:    nxt_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: nxt_state = S_MEMADR;
          OP_RTYPE:          nxt_state = S_EXECUTER;
          OP_ITYPE:          nxt_state = S_EXECUTEI;
          OP_JAL:            nxt_state = S_JAL;
          OP_BRANCH:         nxt_state = S_BEQ;
          default:           nxt_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   nxt_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt_state = S_MEMWB;
      S_MEMWB:    nxt_state = S_FETCH;
      S_MEMWRITE: nxt_state = S_FETCH;
      S_EXECUTER: nxt_state = S_ALUWB;
      S_EXECUTEI: nxt_state = S_ALUWB;
      S_ALUWB:    nxt_state = S_FETCH;
      S_JAL:      nxt_state = S_ALUWB;
      S_BEQ:      nxt_state = S_FETCH;
      S_ILLEGAL:  nxt_state = S_ILLEGAL;
      default:    nxt_state = S_ILLEGAL;
    endcase
  end

  always_comb begin
    adr_src_raw   = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_mode      = ALU_ADD;
    illegal       = 1'b0;
    case (cur_state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src_raw = 1'b1;
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_raw   = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_mode  = ALU_DEC;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_mode  = ALU_DEC;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_mode  = ALU_SUB;
        branch    = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

  // op[5] separates R-type sub from I-type addi, which reuses funct7b5 as an immediate bit
  always_comb begin
    alu_control = 3'b000;
    case (alu_mode)
      ALU_SUB: alu_control = 3'b001;
      ALU_DEC: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  // Enables are masked by reset so an abort never lets a write strobe through
  assign pc_write  = ~reset & (pc_update | (branch & zero));
  assign adr_src   = adr_src_raw;
  assign mem_write = ~reset & mem_write_raw;
  assign ir_write  = ~reset & ir_write_raw;
  assign reg_write = ~reset & reg_write_raw;

  assign retire = (cur_state == S_MEMWB) || (cur_state == S_MEMWRITE) ||
                  (cur_state == S_ALUWB) || (cur_state == S_BEQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + RETIRE_ONE;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
// Instret is 3 bits wide here so the directed sequence wraps the counter.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  logic [2:0] instret;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [23:0] v;
  } exp_t;

  exp_t exp_q[$];

  multicycle_controller #(.RETIRE_CNT_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .reg_write(reg_write),
    .illegal(illegal), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  // Packed as {state,pc_write,adr_src,mem_write,ir_write,result_src,a,b,alu,imm,reg_write,illegal,instret}
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, {state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                   alu_src_b, alu_control, imm_src, reg_write, illegal, instret}, e.v);
      end
    end
  end

  task automatic push(input string nm, input logic [3:0] st, input logic pcw, input logic adr,
                      input logic mw, input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                      input logic [1:0] sb, input logic [2:0] alu, input logic [1:0] imm,
                      input logic rw, input logic ill, input logic [2:0] ret);
    exp_t e;
    e.nm = nm;
    e.v  = {st, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill, ret};
    exp_q.push_back(e);
  endtask

  task automatic step(input string nm, input logic [3:0] st, input logic pcw, input logic adr,
                      input logic mw, input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                      input logic [1:0] sb, input logic [2:0] alu, input logic [1:0] imm,
                      input logic rw, input logic ill, input logic [2:0] ret);
    push(nm, st, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill, ret);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string nm, input logic [1:0] imm, input logic [2:0] ret);
    step(nm, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0, ret);
  endtask

  task automatic decode(input string nm, input logic [1:0] imm, input logic [2:0] ret);
    step(nm, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, 1'b0, ret);
  endtask

  task automatic in_reset(input string nm, input logic [1:0] imm);
    step(nm, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  task automatic alu_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [2:0] alu, input logic [2:0] ret);
    set_instr(o, f3, f7, 1'b0);
    fetch({nm, "_fetch"}, 2'b00, ret);
    decode({nm, "_decode"}, 2'b00, ret);
    if (o == 7'b0110011)
      step({nm, "_exr"}, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu, 2'b00, 1'b0, 1'b0, ret);
    else
      step({nm, "_exi"}, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu, 2'b00, 1'b0, 1'b0, ret);
    step({nm, "_aluwb"}, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, ret);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout act=running req=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_reset("reset_state", 2'b00);
    reset = 1'b0;

    fetch("lw_fetch", 2'b00, 3'd0);
    decode("lw_decode", 2'b00, 3'd0);
    step("lw_memadr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 3'd0);
    step("lw_memread", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 3'd0);
    step("lw_memwb", 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 3'd0);

    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    fetch("sw_fetch", 2'b01, 3'd1);
    decode("sw_decode", 2'b01, 3'd1);
    step("sw_memadr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0, 1'b0, 3'd1);
    step("sw_memwrite", 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0, 3'd1);

    set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
    fetch("beq_t_fetch", 2'b10, 3'd2);
    decode("beq_t_decode", 2'b10, 3'd2);
    step("beq_taken", 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0, 1'b0, 3'd2);

    set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
    fetch("beq_n_fetch", 2'b10, 3'd3);
    decode("beq_n_decode", 2'b10, 3'd3);
    step("beq_not_taken", 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0, 1'b0, 3'd3);

    alu_instr("r_sub", 7'b0110011, 3'b000, 1'b1, 3'b001, 3'd4);
    alu_instr("addi", 7'b0010011, 3'b000, 1'b1, 3'b000, 3'd5);
    alu_instr("r_and", 7'b0110011, 3'b111, 1'b0, 3'b010, 3'd6);
    alu_instr("r_slt", 7'b0110011, 3'b010, 1'b0, 3'b101, 3'd7);

    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    fetch("jal_fetch", 2'b11, 3'd0);
    decode("jal_decode", 2'b11, 3'd0);
    step("jal_jal", 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 1'b0, 1'b0, 3'd0);
    step("jal_aluwb", 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1'b1, 1'b0, 3'd0);

    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    fetch("swab_fetch", 2'b01, 3'd1);
    decode("swab_decode", 2'b01, 3'd1);
    step("swab_memadr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0, 1'b0, 3'd1);
    push("swab_memwrite", 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0, 3'd1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_same_cycle", {19'd0, mem_write, state}, 24'd0);
    chk("abort_instret", {21'd0, instret}, 24'd0);
    @(posedge clk);
    #1;
    in_reset("abort_held", 2'b01);
    set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
    reset = 1'b0;

    fetch("ill_fetch", 2'b00, 3'd0);
    decode("ill_decode", 2'b00, 3'd0);
    for (int i = 0; i < 20; i++)
      step("ill_sticky", 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1, 3'd0);
    reset = 1'b1;
    #1;
    in_reset("ill_reset", 2'b00);
    reset = 1'b0;
    fetch("ill_recover", 2'b00, 3'd0);

    @(negedge clk);
    #1;
    chk("queue_drained", 24'(exp_q.size()), 24'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
